// File: rtl/write_back_stage_pkg.sv
// Shared types and widths for the write-back stage and its load extractor.
package corePckg;

    localparam int cDataWidth  = 32;
    localparam int cRegSelBitW = 5;
    localparam int cRetireCntW = 32;

    typedef struct packed {
        logic                   en;
        logic [cRegSelBitW-1:0] addr;
    } tRegControl;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } tLoadType;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } tWbSrc;

endpackage

// File: rtl/write_back_stage_load_extend.sv
// Combinational load-data extraction: byte/halfword select by offset,
// sign/zero extension by funct3, plus illegal-funct3 and misaligned flags.
module load_extend
    import corePckg::*;
(
    input  logic [cDataWidth-1:0] data_i,
    input  logic [1:0]            off_i,
    input  logic [2:0]            funct3_i,
    output logic [cDataWidth-1:0] data_o,
    output logic                  illegal_o,
    output logic                  misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = 8'(data_i >> {off_i, 3'b000});
    // Halfword position uses only the upper offset bit; the low bit only feeds the misalign flag.
    assign half_sel = 16'(data_i >> {off_i[1], 4'b0000});

    always_comb begin
        data_o     = '0;
        illegal_o  = 1'b0;
        misalign_o = 1'b0;
        case (funct3_i)
            LB:  data_o = {{(cDataWidth-8){byte_sel[7]}}, byte_sel};
            LBU: data_o = {{(cDataWidth-8){1'b0}}, byte_sel};
            LH: begin
                data_o     = {{(cDataWidth-16){half_sel[15]}}, half_sel};
                misalign_o = off_i[0];
            end
            LHU: begin
                data_o     = {{(cDataWidth-16){1'b0}}, half_sel};
                misalign_o = off_i[0];
            end
            LW: begin
                data_o     = data_i;
                misalign_o = (off_i != 2'b00);
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// Round-robin write-back arbiter between ALU and load results, driving the
// register-file write port and decode bypass. Optional: WB_MISALIGN_CHK_EN.
module write_back_stage
    import corePckg::*;
#(
    parameter int DATA_W = cDataWidth,
    parameter int ADDR_W = cRegSelBitW,
    parameter int CNT_W  = cRetireCntW
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStall,
    input  logic              aluVld,
    output logic              aluRdy,
    input  logic [ADDR_W-1:0] aluAddr,
    input  logic [DATA_W-1:0] aluData,
    input  logic              memVld,
    output logic              memRdy,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memData,
    input  logic [1:0]        memOff,
    input  logic [2:0]        memFunct3,
    output tRegControl        rdCntrl,
    output logic [DATA_W-1:0] rdData,
    output tRegControl        fwdCntrl,
    output logic [DATA_W-1:0] fwdData,
    output logic [CNT_W-1:0]  oRetireCnt,
`ifdef WB_MISALIGN_CHK_EN
    output logic              oMisalign,
`endif
    output logic              oBadFunct3
);

    logic [DATA_W-1:0] load_data;
    logic              load_illegal;
    logic              load_misalign;

    load_extend u_load_extend (
        .data_i     (memData),
        .off_i      (memOff),
        .funct3_i   (memFunct3),
        .data_o     (load_data),
        .illegal_o  (load_illegal),
        .misalign_o (load_misalign)
    );

    tRegControl        rd_cntrl_q, rd_cntrl_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic              bad_q, bad_d;
    tWbSrc             last_grant_q, last_grant_d;

    logic              grant_alu, grant_mem, xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_bad, sel_mis, suppress;

    // On a tie the source that did not win last time is granted.
    assign grant_alu = !iStall && aluVld && (!memVld || last_grant_q == SRC_MEM);
    assign grant_mem = !iStall && memVld && (!aluVld || last_grant_q == SRC_ALU);
    assign xfer      = grant_alu || grant_mem;
    assign aluRdy    = grant_alu;
    assign memRdy    = grant_mem;

    assign sel_addr = grant_mem ? memAddr : aluAddr;
    assign sel_data = grant_mem ? load_data : aluData;
    assign sel_bad  = grant_mem && load_illegal;
    assign sel_mis  = grant_mem && load_misalign;

`ifdef WB_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;
    assign suppress   = (sel_addr == '0) || sel_bad || sel_mis;
    assign misalign_d = xfer && sel_mis;
    assign oMisalign  = misalign_q;
`else
    logic misalign_unused;
    assign misalign_unused = sel_mis;
    assign suppress        = (sel_addr == '0) || sel_bad;
`endif

    always_comb begin
        rd_cntrl_d   = rd_cntrl_q;
        rd_data_d    = rd_data_q;
        last_grant_d = last_grant_q;
        rd_cntrl_d.en = 1'b0;
        if (xfer) begin
            rd_cntrl_d.en   = !suppress;
            rd_cntrl_d.addr = sel_addr;
            rd_data_d       = suppress ? '0 : sel_data;
            last_grant_d    = grant_mem ? SRC_MEM : SRC_ALU;
        end
        bad_d        = xfer && sel_bad;
        retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, xfer};
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rd_cntrl_q   <= '0;
            rd_data_q    <= '0;
            retire_cnt_q <= '0;
            bad_q        <= 1'b0;
            last_grant_q <= SRC_ALU;
`ifdef WB_MISALIGN_CHK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            rd_cntrl_q   <= rd_cntrl_d;
            rd_data_q    <= rd_data_d;
            retire_cnt_q <= retire_cnt_d;
            bad_q        <= bad_d;
            last_grant_q <= last_grant_d;
`ifdef WB_MISALIGN_CHK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign rdCntrl    = rd_cntrl_q;
    assign rdData     = rd_data_q;
    assign fwdCntrl   = rd_cntrl_q;
    assign fwdData    = rd_data_q;
    assign oRetireCnt = retire_cnt_q;
    assign oBadFunct3 = bad_q;

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
Write-back stage sitting directly upstream of the register file. It accepts completed results from the ALU and load paths through valid/ready handshakes and arbitrates between them round-robin. Load data is byte-selected and sign/zero-extended per funct3. It then drives the register file write port (rdCntrl/rdData) one cycle later and exposes the same registered result as a bypass for decode.

Parameters:
DATA_W, cDataWidth (32), datapath width; must be 32.
ADDR_W, cRegSelBitW (5), register index width.
CNT_W, 32, width of the retired-instruction counter.

Ports:
iClk  in  1  clock.
iRst  in  1  asynchronous reset, active-high.
iStall  in  1  hold request from hazard unit; no source is granted while high.
aluVld  in  1  ALU result valid.
aluRdy  out  1  ALU result accepted this cycle.
aluAddr  in  ADDR_W  destination register.
aluData  in  DATA_W  ALU result.
memVld  in  1  load result valid.
memRdy  out  1  load result accepted this cycle.
memAddr  in  ADDR_W  destination register.
memData  in  DATA_W  aligned 32-bit word from data memory.
memOff  in  2  byte offset of the load address.
memFunct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
rdCntrl  out  tRegControl  register-file write control (en, addr).
rdData  out  DATA_W  register-file write data.
fwdCntrl  out  tRegControl  bypass control, identical to rdCntrl.
fwdData  out  DATA_W  bypass data, identical to rdData.
oRetireCnt  out  CNT_W  count of accepted results.
oBadFunct3  out  1  one-cycle pulse: a load with an illegal funct3 was accepted.

Behaviour:
- Interface decided: one clock iClk; reset iRst asynchronous, active-high.
- Reset values:
  - rdCntrl.en=0, rdCntrl.addr=0, rdData=0 (fwd* identical).
  - oRetireCnt=0, oBadFunct3=0.
  - lastGrant=ALU.
- Grant logic (combinational):
  - If iStall=1, both rdy=0.
  - Else, with one source valid, that source is granted.
  - With both valid, the source not in lastGrant is granted. After reset, this means MEM wins the first tie.
  - rdy = grant. A transfer occurs on vld&rdy.
  - Ready never depends on downstream, because the register file always accepts.
- lastGrant updates only on a transfer.
- Latency: a transfer in cycle N gives rdCntrl.en=1 with addr/data in cycle N+1. Each result is a single-cycle write.
- With no transfer in cycle N, rdCntrl.en=0 in cycle N+1 and rdCntrl.addr/rdData hold their previous values.
- Destination x0: the transfer is still accepted and counted, but rdCntrl.en=0 and rdData=0.
- Load extraction (per funct3):
  - LB/LBU: byte memData[8*memOff +: 8], sign- or zero-extended respectively.
  - LH/LHU: halfword memData[16*memOff[1] +: 16]; memOff[0] is ignored unless the optional feature is enabled.
  - LW: memData unchanged.
- Illegal funct3 (011, 110, 111): write data=0, write is suppressed (en=0), oBadFunct3 pulses in N+1, counter still increments.
- oRetireCnt increments by 1 per transfer and wraps at 2^CNT_W-1 to 0.
- Asynchronous reset mid-operation: every register returns to its reset value immediately, and any in-flight result is dropped.
- iStall asserted while a result is already registered does not cancel that registered result. It only blocks new grants.

Optional Feature:
WB_MISALIGN_CHK_EN.
- Defined: adds output oMisalign (1 bit). An LH/LHU with memOff[0]=1, or an LW with memOff!=0, is accepted and counted, but its write is suppressed (en=0). oMisalign pulses in N+1.
- Undefined: no oMisalign port. Misaligned loads use the extraction rules above, ignoring the low offset bits.

Decomposition:
- corePckg:
  - tRegControl (reused).
  - New enum tLoadType (LB, LH, LW, LBU, LHU).
  - New enum tWbSrc (SRC_ALU, SRC_MEM).
  - Constant cRetireCntW.
- One sub-module, load_extend: purely combinational extraction and extension from memData/memOff/memFunct3. It also outputs an illegal-funct3 flag and a misaligned flag.
- Arbitration and the output registers stay in write_back_stage.

Test Plan:
- ALU only: aluVld=1, aluAddr=5, aluData=0xDEADBEEF. Required: aluRdy=1 same cycle; next cycle rdCntrl={1,5}, rdData=0xDEADBEEF, oRetireCnt=1.
- Load extension: memData=0x8070F0FF.
  - LB, off=1 → 0xFFFFFFF0.
  - LBU, off=1 → 0x000000F0.
  - LH, off=2 → 0xFFFF8070.
  - LHU, off=2 → 0x00008070.
  - LW → 0x8070F0FF.
- Contention: aluVld=memVld=1 held for 4 cycles after reset. Required grant order MEM, ALU, MEM, ALU; exactly one rdy per cycle; oRetireCnt=4.
- x0 and stall: a write to addr 0 gives rdCntrl.en=0 with the counter incremented. iStall=1 with both valid gives both rdy=0 and en=0 in the following cycle.
- Reset mid-stream: assert iRst asynchronously between clock edges while rdCntrl.en=1. Required: en=0, rdData=0, oRetireCnt=0 immediately; the first tie after release goes to MEM.
- Wrap and illegal: preload the counter to 0xFFFFFFFF via a bench force, then do one transfer → 0. A load with funct3=011 → oBadFunct3 pulses 1 cycle and en=0.
